// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with synchronised rx line, framing checks and break lockout.
// Define UART_RX_PARITY_EN to receive 8E1 frames with parity checking.
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] byte_out,
  output logic       valid_out,
  output logic       frame_error,
  output logic       parity_error,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic [CW-1:0]          cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             shreg;
  logic                   par_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '1;
    else     sync <= {sync[SYNC_STAGES-2:0], rx_in};
  end

  assign rx_s = sync[SYNC_STAGES-1];

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  // Even parity: data bits and parity bit together XOR to zero.
  assign par_ok = ~(^{shreg, par_bit});

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    par_bit <= 1'b0;
    else if (state == ST_PARITY && cnt == BIT_LAST) par_bit <= rx_s;
  end
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (!rx_s) state_next = ST_START;
      ST_START: if (cnt == HALF_LAST) state_next = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:
        if (cnt == BIT_LAST && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_next = ST_PARITY;
`else
          state_next = ST_STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (cnt == BIT_LAST) state_next = ST_STOP;
`endif
      // Leaving STOP at mid-bit gives half a bit of margin to catch the next start edge.
      ST_STOP:  if (cnt == BIT_LAST) state_next = rx_s ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (rx_s) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      byte_out     <= '0;
      valid_out    <= 1'b0;
      frame_error  <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      valid_out    <= 1'b0;
      frame_error  <= 1'b0;
      parity_error <= 1'b0;
      unique case (state)
        ST_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt == BIT_LAST) cnt <= '0;
          else                 cnt <= cnt + CW'(1);
        end
`endif
        ST_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              frame_error <= 1'b1;
            end else if (par_ok) begin
              valid_out <= 1'b1;
              byte_out  <= shreg;
            end else begin
              parity_error <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
